// File: rtl/uart_dfifo_wr_arbiter.sv
// Round-robin arbiter sharing the DFIFO write port between NUM_REQ valid/ready requesters,
// with bounded bursts per grant. Optional per-requester transfer counters under UART_ARB_STATS_EN.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no grant held; picks the next valid requester after last_q
// GRANT  | requester grant_q owns the FIFO write port for up to BURST_LEN beats
module uart_dfifo_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_apb_pclk,
  input  logic                          i_apb_presetn,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_dfifo_full,
  output logic [DATA_WIDTH-1:0]         o_dfifo_input,
  output logic                          o_dfifo_write_req,
  output logic [GW-1:0]                 o_grant_id,
  output logic                          o_busy
`ifdef UART_ARB_STATS_EN
  ,
  input  logic                          i_stats_clr,
  output logic [NUM_REQ*16-1:0]         o_xfer_cnt
`endif
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [7:0]      burst_q, burst_d;
  logic [DATA_WIDTH-1:0] sel_data;
  logic            sel_valid;
  logic            xfer;
  logic            found;
  int              idx;

  // Mux the granted requester's valid and data slice.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_data  = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = i_req_valid[i];
      end
    end
  end

  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    burst_d           = burst_q;
    o_req_ready       = '0;
    xfer              = 1'b0;
    o_dfifo_write_req = 1'b0;
    o_dfifo_input     = '0;
    found             = 1'b0;
    idx               = 0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && |i_req_valid) begin
          // Scan starting just after the last grant so every requester gets a turn.
          for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
              if (!found && (j == idx) && i_req_valid[j]) begin
                found   = 1'b1;
                grant_d = GW'(j);
              end
            end
          end
          burst_d = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == GW'(i)) o_req_ready[i] = i_enable && !i_dfifo_full;
        end
        xfer = sel_valid && i_enable && !i_dfifo_full;
        if (xfer) begin
          o_dfifo_write_req = 1'b1;
          o_dfifo_input     = sel_data;
          burst_d           = burst_q + 8'd1;
          if (burst_q == 8'(BURST_LEN - 1)) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end else if (!sel_valid || !i_enable) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_grant_id = grant_q;
  assign o_busy     = (state_q == ST_GRANT);

`ifdef UART_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  // Clear has priority over a same-cycle transfer; counters saturate.
  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_stats_clr) begin
          cnt_q[i] <= '0;
        end else if (xfer && (grant_q == GW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    o_xfer_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) o_xfer_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_uart_dfifo_wr_arbiter.sv
// Directed bench for uart_dfifo_wr_arbiter (NUM_REQ=2, DATA_WIDTH=8, BURST_LEN=4).
// Counter checks are compiled only when UART_ARB_STATS_EN is defined.
module tb_uart_dfifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  valid = '0;
  logic [7:0]  d0 = '0;
  logic [7:0]  d1 = '0;
  logic [1:0]  ready;
  logic        full = 1'b0;
  logic [7:0]  din;
  logic        wr;
  logic        gid;
  logic        busy;
`ifdef UART_ARB_STATS_EN
  logic        clr = 1'b0;
  logic [31:0] xcnt;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_dfifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .i_apb_pclk(clk),
    .i_apb_presetn(rst_n),
    .i_enable(en),
    .i_req_valid(valid),
    .i_req_data({d1, d0}),
    .o_req_ready(ready),
    .i_dfifo_full(full),
    .o_dfifo_input(din),
    .o_dfifo_write_req(wr),
    .o_grant_id(gid),
    .o_busy(busy)
`ifdef UART_ARB_STATS_EN
    ,
    .i_stats_clr(clr),
    .o_xfer_cnt(xcnt)
`endif
  );

  // Drive inputs on the falling edge, then let combinational outputs settle.
  task automatic cyc(input logic e, input logic [1:0] v, input logic f);
    @(negedge clk);
    en = e; valid = v; full = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; valid = '0; full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; valid = 2'b11; d0 = 8'h5A; d1 = 8'h3C;
    @(negedge clk); #1;
    total++; if (wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", wr); end
    total++; if (ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (din !== 8'h00) begin bad++; $display("FAIL reset_din got=%h exp=00", din); end
    total++; if (gid !== 1'b0) begin bad++; $display("FAIL reset_gid got=%b exp=0", gid); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    d0 = 8'hA5;
    cyc(1'b1, 2'b01, 1'b0);
    total++; if (wr !== 1'b0 || busy !== 1'b0 || ready !== 2'b00) begin
      bad++; $display("FAIL single_idle wr=%b busy=%b ready=%b exp 0 0 00", wr, busy, ready); end
    cyc(1'b1, 2'b01, 1'b0);
    total++; if (wr !== 1'b1 || din !== 8'hA5) begin
      bad++; $display("FAIL single_write wr=%b din=%h exp 1 a5", wr, din); end
    total++; if (gid !== 1'b0 || ready !== 2'b01 || busy !== 1'b1) begin
      bad++; $display("FAIL single_grant gid=%b ready=%b busy=%b exp 0 01 1", gid, ready, busy); end
    cyc(1'b1, 2'b00, 1'b0);
    total++; if (wr !== 1'b0 || din !== 8'h00) begin
      bad++; $display("FAIL single_nodata wr=%b din=%h exp 0 00", wr, din); end
    cyc(1'b1, 2'b00, 1'b0);
    total++; if (busy !== 1'b0 || gid !== 1'b0) begin
      bad++; $display("FAIL single_hold busy=%b gid=%b exp 0 0", busy, gid); end
  endtask

  task automatic test_round_robin();
    logic ew;
    logic src;
    logic [7:0] ed;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      d0 = 8'h10 + 8'(c);
      d1 = 8'h80 + 8'(c);
      cyc(1'b1, 2'b11, 1'b0);
      ew  = !(c == 0 || c == 5 || c == 10);
      src = (c >= 6 && c <= 9);
      ed  = ew ? (src ? 8'h80 + 8'(c) : 8'h10 + 8'(c)) : 8'h00;
      total++; if (wr !== ew || din !== ed) begin
        bad++; $display("FAIL rr_write c=%0d wr=%b din=%h exp %b %h", c, wr, din, ew, ed); end
      if (ew) begin
        total++; if (gid !== src || ready !== (src ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL rr_grant c=%0d gid=%b ready=%b exp src=%b", c, gid, ready, src); end
      end
    end
  endtask

  task automatic test_full_stall();
    logic ef;
    logic ew;
    do_reset();
    d1 = 8'hC3;
    for (int c = 0; c < 11; c++) begin
      ef = (c >= 3 && c <= 7);
      cyc(1'b1, 2'b10, ef);
      ew = (c == 1 || c == 2 || c == 8 || c == 9);
      total++; if (wr !== ew) begin
        bad++; $display("FAIL full_write c=%0d wr=%b exp=%b", c, wr, ew); end
      if (ef) begin
        total++; if (ready !== 2'b00 || busy !== 1'b1 || din !== 8'h00) begin
          bad++; $display("FAIL full_stall c=%0d ready=%b busy=%b din=%h exp 00 1 00", c, ready, busy, din); end
      end
      if (ew) begin
        total++; if (ready !== 2'b10 || gid !== 1'b1 || din !== 8'hC3) begin
          bad++; $display("FAIL full_grant c=%0d ready=%b gid=%b din=%h exp 10 1 c3", c, ready, gid, din); end
      end
      if (c == 10) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_end busy=%b exp=0", busy); end
      end
    end
  endtask

  task automatic test_drop_valid();
    do_reset();
    d0 = 8'h11; d1 = 8'h22;
    cyc(1'b1, 2'b11, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
    total++; if (wr !== 1'b1 || din !== 8'h11) begin
      bad++; $display("FAIL drop_first wr=%b din=%h exp 1 11", wr, din); end
    cyc(1'b1, 2'b10, 1'b0);
    total++; if (wr !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL drop_cycle wr=%b busy=%b exp 0 1", wr, busy); end
    cyc(1'b1, 2'b10, 1'b0);
    total++; if (busy !== 1'b0 || wr !== 1'b0) begin
      bad++; $display("FAIL drop_idle busy=%b wr=%b exp 0 0", busy, wr); end
    cyc(1'b1, 2'b10, 1'b0);
    total++; if (wr !== 1'b1 || gid !== 1'b1 || din !== 8'h22) begin
      bad++; $display("FAIL drop_other wr=%b gid=%b din=%h exp 1 1 22", wr, gid, din); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    d0 = 8'h4E;
    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    total++; if (wr !== 1'b1) begin bad++; $display("FAIL en_first wr=%b exp=1", wr); end
    cyc(1'b0, 2'b01, 1'b0);
    total++; if (ready !== 2'b00 || wr !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL en_drop ready=%b wr=%b busy=%b exp 00 0 1", ready, wr, busy); end
    for (int c = 0; c < 2; c++) begin
      cyc(1'b0, 2'b01, 1'b0);
      total++; if (busy !== 1'b0 || wr !== 1'b0 || ready !== 2'b00) begin
        bad++; $display("FAIL en_off c=%0d busy=%b wr=%b ready=%b exp 0 0 00", c, busy, wr, ready); end
    end
    cyc(1'b1, 2'b01, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_rearb busy=%b exp=0", busy); end
    cyc(1'b1, 2'b01, 1'b0);
    total++; if (wr !== 1'b1 || gid !== 1'b0 || din !== 8'h4E) begin
      bad++; $display("FAIL en_resume wr=%b gid=%b din=%h exp 1 0 4e", wr, gid, din); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    d0 = 8'h77;
    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (wr !== 1'b0 || busy !== 1'b0 || ready !== 2'b00 || gid !== 1'b0) begin
      bad++; $display("FAIL midrst wr=%b busy=%b ready=%b gid=%b exp 0 0 00 0", wr, busy, ready, gid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef UART_ARB_STATS_EN
  task automatic test_stats();
    int writes;
    int cycles;
    do_reset();
    d0 = 8'h01;
    writes = 0;
    cycles = 0;
    cyc(1'b1, 2'b01, 1'b0);
    while (writes < 70000 && cycles < 95000) begin
      if (wr === 1'b1) writes++;
      cycles++;
      @(negedge clk); #1;
    end
    total++; if (writes != 70000) begin
      bad++; $display("FAIL stats_budget writes=%0d exp=70000", writes); end
    total++; if (xcnt[15:0] !== 16'hFFFF || xcnt[31:16] !== 16'h0000) begin
      bad++; $display("FAIL stats_sat cnt0=%h cnt1=%h exp ffff 0000", xcnt[15:0], xcnt[31:16]); end
    cycles = 0;
    while (wr !== 1'b1 && cycles < 10) begin
      @(negedge clk); #1;
      cycles++;
    end
    clr = 1'b1;
    total++; if (wr !== 1'b1) begin bad++; $display("FAIL stats_clr_align wr=%b exp=1", wr); end
    @(negedge clk);
    clr = 1'b0; valid = 2'b00;
    #1;
    total++; if (xcnt[15:0] !== 16'h0000) begin
      bad++; $display("FAIL stats_clr cnt0=%h exp=0000", xcnt[15:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop_valid();
    test_enable_drop();
    test_reset_mid_burst();
`ifdef UART_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
